// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared constants and helpers for the UART blocks.
//
// Contents:
//   DEF_CLK_HZ   default fabric clock frequency (Hz)
//   DEF_FRAC_W   default width of the fractional divisor
//   MIN_DIV_INT  smallest integer divisor the baud generator accepts
//   baud_div_fx  fixed-point oversample divisor:
//                (clk_hz * 2^frac_w) / (baud * ovs), truncated
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ  = 100_000_000;
  localparam int unsigned DEF_FRAC_W  = 4;

  // A divisor of 1 would leave no room for a counter phase; 2 is the floor.
  localparam int unsigned MIN_DIV_INT = 2;

  // Fixed-point divisor with frac_w fractional bits. The integer part sits in
  // the upper bits, the fraction in the low frac_w bits.
  function automatic longint unsigned baud_div_fx(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs,
    input int unsigned     frac_w
  );
    return (clk_hz << frac_w) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// -----------------------------------------------------------------------------
// uart_frac_div
//
// Fractional clock divider producing the raw oversample strobe. Each period
// lasts act_int cycles, plus one when the previous period's accumulation of
// act_frac overflowed, so the long-run period is act_int + act_frac/2^FRAC_W.
//
// Ports:
//   clk        in   fabric clock
//   rst_n      in   asynchronous active-low reset
//   run        in   count when high; when low all counters clear
//   load       in   copy load_int/load_frac into the active divisor
//   load_int   in   CNT_W   integer divisor to activate
//   load_frac  in   FRAC_W  fractional divisor to activate
//   wrap       out  combinational: this edge ends an oversample period
// -----------------------------------------------------------------------------
module uart_frac_div #(
  parameter int unsigned       CNT_W    = 16,
  parameter int unsigned       FRAC_W   = 4,
  parameter logic [CNT_W-1:0]  DEF_INT  = CNT_W'(54),
  parameter logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_int,
  input  logic [FRAC_W-1:0] load_frac,
  output logic              wrap
);

  logic [CNT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              c;
  logic [CNT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W:0]   acc_sum;

  // NOTE: always_comb outputs are assigned on every path (here unconditionally),
  // which is what keeps synthesis from inferring latches.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, act_frac};
    // Period length is act_int + c; compare against its last count value
    // without forming act_int + c, which could overflow CNT_W bits.
    wrap    = run && (c ? (cnt == act_int) : (cnt == act_int - CNT_W'(1)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      c        <= 1'b0;
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
    end else begin
      if (!run) begin
        cnt <= '0;
        acc <= '0;
        c   <= 1'b0;
      end else if (wrap) begin
        cnt      <= '0;
        {c, acc} <= acc_sum;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Loads coincide only with wrap or !run, so cnt is always 0 when the
      // divisor changes and can never sit beyond a shrunken period.
      if (load) begin
        act_int  <= load_int;
        act_frac <= load_frac;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-rate generator shared by the UART transmitter and receiver. Produces
// three single-cycle strobes from the fabric clock: an oversample tick, a
// mid-bit sample tick and a bit-boundary tick. The divisor is fractional and
// can be reloaded at runtime through a shadow register that becomes active
// on an oversample boundary (or immediately while counting is stopped).
//
// Ports:
//   clk          in   fabric clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   count enable; low holds and clears all counters
//   restart      in   synchronous phase realign; clears all counters
//   div_int      in   CNT_W   new integer divisor (values below 2 become 2)
//   div_frac     in   FRAC_W  new fractional divisor
//   div_load     in   one-cycle strobe capturing div_int/div_frac
//   ovs_tick     out  oversample strobe
//   mid_tick     out  mid-bit sample strobe
//   bit_tick     out  bit-boundary strobe
//   div_pending  out  captured divisor not yet active
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned OVS    = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              ovs_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              div_pending
);

  localparam longint unsigned DIV_FX =
    baud_div_fx(64'(CLK_HZ), 64'(BAUD), 64'(OVS), FRAC_W);

  localparam logic [CNT_W-1:0]  DEF_INT  = CNT_W'(DIV_FX >> FRAC_W);
  // Truncating to FRAC_W bits is the modulo 2^FRAC_W.
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DIV_FX);
  localparam logic [CNT_W-1:0]  MIN_INT  = CNT_W'(MIN_DIV_INT);

  localparam int unsigned       IDX_W    = $clog2(OVS);
  localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OVS / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVS - 1);

  logic              run;
  logic              wrap;
  logic              transfer;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  // restart takes priority over en; either one stops and clears counting.
  assign run      = en && !restart;
  // The shadow moves to the active divisor only on a period boundary or
  // while counting is stopped, so the running period is never disturbed.
  assign transfer = div_pending && (wrap || !run);

  uart_frac_div #(
    .CNT_W    (CNT_W),
    .FRAC_W   (FRAC_W),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) u_frac_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .load      (transfer),
    .load_int  (sh_int),
    .load_frac (sh_frac),
    .wrap      (wrap)
  );

  // Shadow divisor and pending flag. A load in the same cycle as a transfer
  // lands in the shadow after the old shadow has been handed over, so the
  // flag stays set for the newer value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_int      <= DEF_INT;
      sh_frac     <= DEF_FRAC;
      div_pending <= 1'b0;
    end else begin
      if (div_load) begin
        sh_int  <= (div_int < MIN_INT) ? MIN_INT : div_int;
        sh_frac <= div_frac;
      end

      if (div_load) begin
        div_pending <= 1'b1;
      end else if (transfer) begin
        div_pending <= 1'b0;
      end
    end
  end

  // Oversample index and registered tick decode. The index value before the
  // increment selects the strobe, so mid and bit ticks land on distinct
  // oversample events and each coincides with an ovs_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      ovs_tick <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      if (!run) begin
        idx <= '0;
      end else if (wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      // wrap is already gated by run, so ticks drop the edge after en or
      // restart stops counting.
      ovs_tick <= wrap;
      mid_tick <= wrap && (idx == IDX_MID);
      bit_tick <= wrap && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen with default parameters. A behavioural
// model predicts, edge by edge, when each oversample period ends: a period
// length is chosen when the period starts (integer divisor plus one when the
// running fractional residue overflowed), and the model counts it down. The
// strobes, mid/bit decode and shadow-divisor bookkeeping follow from the
// period count. Directed phases additionally measure tick spacing against
// the expected constants.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int CNT_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int OVS     = 16;
  localparam int SCALE   = 16;  // 2^FRAC_W
  localparam longint unsigned DIV_FX =
    (64'd100_000_000 * 64'd16) / (64'd115200 * 64'd16);
  localparam int DEF_INT  = int'(DIV_FX / 64'd16);
  localparam int DEF_FRAC = int'(DIV_FX % 64'd16);
  localparam int BIT_DFLT = int'(DIV_FX);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              restart;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              ovs_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              div_pending;

  uart_baud_gen #(
    .CLK_HZ (100_000_000),
    .BAUD   (115200),
    .OVS    (16),
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .restart     (restart),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .ovs_tick    (ovs_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick),
    .div_pending (div_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_act_i, m_act_f, m_sh_i, m_sh_f;
  int m_rem;   // edges left in the current oversample period
  int m_res;   // fractional residue, 0..SCALE-1
  int m_pos;   // oversample events seen in the current bit, 0..OVS-1
  bit m_pend;
  bit e_ovs, e_mid, e_bit;

  task automatic model_reset();
    m_act_i = DEF_INT;  m_act_f = DEF_FRAC;
    m_sh_i  = DEF_INT;  m_sh_f  = DEF_FRAC;
    m_pend  = 1'b0;
    m_rem   = DEF_INT;
    m_res   = 0;
    m_pos   = 0;
    e_ovs   = 1'b0; e_mid = 1'b0; e_bit = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit run, tick, carry;
    int old_f;
    run   = (en === 1'b1) && (restart !== 1'b1);
    tick  = 1'b0;
    old_f = m_act_f;
    e_mid = 1'b0;
    e_bit = 1'b0;
    if (run) begin
      m_rem = m_rem - 1;
      tick  = (m_rem == 0);
    end
    if (tick) begin
      e_mid = (m_pos == OVS / 2 - 1);
      e_bit = (m_pos == OVS - 1);
      m_pos = (m_pos + 1) % OVS;
    end
    e_ovs = tick;
    if (m_pend && (tick || !run)) begin
      m_act_i = m_sh_i;
      m_act_f = m_sh_f;
      m_pend  = 1'b0;
    end
    if (div_load === 1'b1) begin
      m_sh_i = (int'(div_int) < 2) ? 2 : int'(div_int);
      m_sh_f = int'(div_frac);
      m_pend = 1'b1;
    end
    if (!run) begin
      m_res = 0;
      m_pos = 0;
      m_rem = m_act_i;
    end else if (tick) begin
      m_res = m_res + old_f;
      carry = (m_res >= SCALE);
      m_res = m_res % SCALE;
      m_rem = m_act_i + int'(carry);
    end
  endtask

  // ---------------- measurement ----------------
  int cyc;
  int ovs_q[$];
  int mid_q[$];
  int bit_q[$];

  task automatic clear_meas();
    cyc = 0;
    ovs_q.delete();
    mid_q.delete();
    bit_q.delete();
  endtask

  // One clock edge: advance the model, then sample the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("ovs_tick",    32'(ovs_tick),    32'(e_ovs));
    check("mid_tick",    32'(mid_tick),    32'(e_mid));
    check("bit_tick",    32'(bit_tick),    32'(e_bit));
    check("div_pending", 32'(div_pending), 32'(m_pend));
    if (ovs_tick === 1'b1) ovs_q.push_back(cyc);
    if (mid_tick === 1'b1) mid_q.push_back(cyc);
    if (bit_tick === 1'b1) bit_q.push_back(cyc);
  endtask

  task automatic run_until_ovs(input string tag, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (ovs_tick === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    int iv;
    int prev_iv;
    int drops;
    bit seen;

    rst_n    = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    div_load = 1'b0;
    div_int  = '0;
    div_frac = '0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovs",  32'(ovs_tick),    32'd0);
    check("rst_mid",  32'(mid_tick),    32'd0);
    check("rst_bit",  32'(bit_tick),    32'd0);
    check("rst_pend", 32'(div_pending), 32'd0);
    rst_n = 1'b1;
    repeat (5) step();

    // Defaults, en high for 2000 cycles.
    en = 1'b1;
    clear_meas();
    repeat (2000) step();
    check("first_ovs", (ovs_q.size() > 0) ? ovs_q[0] : -1, DEF_INT);
    for (int k = 1; k < 9 && k < ovs_q.size(); k++)
      check("period_dflt", ovs_q[k] - ovs_q[k-1],
            (((k + 1) % 4) == 1) ? DEF_INT + 1 : DEF_INT);
    check("bit_count_dflt", bit_q.size(), 2);
    if (bit_q.size() >= 2) check("bit_space_dflt", bit_q[1] - bit_q[0], BIT_DFLT);
    check("mid_count_dflt", mid_q.size(), 2);
    if (mid_q.size() >= 2 && bit_q.size() >= 1)
      check("mid_offset_dflt", mid_q[1] - bit_q[0], BIT_DFLT / 2);

    // Drop en for 10 cycles mid-bit, then re-enable.
    en = 1'b0;
    clear_meas();
    repeat (10) step();
    check("no_ticks_en_low", ovs_q.size() + mid_q.size() + bit_q.size(), 0);
    en = 1'b1;
    clear_meas();
    run_until_ovs("reen_wait", 200, at);
    check("reen_first", at, DEF_INT);

    // Load 6 + 8/16 mid-period.
    repeat (20) step();
    div_load = 1'b1;
    div_int  = 16'd6;
    div_frac = 4'd8;
    step();
    div_load = 1'b0;
    check("pend_set", 32'(div_pending), 32'd1);
    drops = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (ovs_tick === 1'b1) seen = 1'b1;
      else if (div_pending !== 1'b1) drops++;
    end
    check("pend_hold_tick", 32'(seen), 32'd1);
    check("pend_hold",      drops, 0);
    check("pend_clear",     32'(div_pending), 32'd0);
    clear_meas();
    repeat (1200) step();
    prev_iv = 0;
    for (int k = 2; k < 14 && k < ovs_q.size(); k++) begin
      iv = ovs_q[k] - ovs_q[k-1];
      check("period_6_7", 32'(iv == 6 || iv == 7), 32'd1);
      if (k > 2) check("period_alt", 32'(iv != prev_iv), 32'd1);
      prev_iv = iv;
    end
    check("bit104_count", 32'(bit_q.size() >= 4), 32'd1);
    for (int k = 1; k < 5 && k < bit_q.size(); k++)
      check("bit_space_104", bit_q[k] - bit_q[k-1], 104);

    // Clamp: div_int = 0 becomes 2, fraction 5/16.
    div_load = 1'b1;
    div_int  = 16'd0;
    div_frac = 4'd5;
    step();
    div_load = 1'b0;
    run_until_ovs("clamp_xfer", 100, at);
    clear_meas();
    repeat (400) step();
    for (int k = 1; k < 25 && k < ovs_q.size(); k++) begin
      iv = ovs_q[k] - ovs_q[k-1];
      check("period_2_3", 32'(iv == 2 || iv == 3), 32'd1);
    end
    check("bit37_count", 32'(bit_q.size() >= 4), 32'd1);
    for (int k = 1; k < 5 && k < bit_q.size(); k++)
      check("bit_space_37", bit_q[k] - bit_q[k-1], 2 * OVS + 5);

    // restart with div_load, restart held one more edge to activate it.
    div_int  = 16'd10;
    div_frac = 4'd0;
    restart  = 1'b1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("rs_pend_set", 32'(div_pending), 32'd1);
    step();
    restart = 1'b0;
    check("rs_pend_clr", 32'(div_pending), 32'd0);
    check("rs_no_tick",  32'(ovs_tick),    32'd0);
    clear_meas();
    run_until_ovs("rs_wait", 100, at);
    check("rs_first", at, 10);
    repeat (30) step();
    for (int k = 1; k < ovs_q.size(); k++)
      check("rs_period", ovs_q[k] - ovs_q[k-1], 10);

    // Async reset while a tick is high and a load is pending.
    run_until_ovs("pre_rst_sync", 20, at);
    repeat (9) step();
    div_load = 1'b1;
    div_int  = 16'd20;
    div_frac = 4'd3;
    step();
    div_load = 1'b0;
    check("pre_rst_ovs",  32'(ovs_tick),    32'd1);
    check("pre_rst_pend", 32'(div_pending), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ovs",  32'(ovs_tick),    32'd0);
    check("async_rst_mid",  32'(mid_tick),    32'd0);
    check("async_rst_bit",  32'(bit_tick),    32'd0);
    check("async_rst_pend", 32'(div_pending), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_meas();
    repeat (150) step();
    check("post_rst_first", (ovs_q.size() > 0) ? ovs_q[0] : -1, DEF_INT);
    for (int k = 1; k < 3 && k < ovs_q.size(); k++)
      check("post_rst_period", ovs_q[k] - ovs_q[k-1], DEF_INT);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      restart  = ($urandom_range(0, 199) == 0);
      div_load = ($urandom_range(0, 39) == 0);
      div_int  = CNT_W'($urandom_range(0, 12));
      div_frac = FRAC_W'($urandom);
      step();
    end
    div_load = 1'b0;
    restart  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud-rate generator shared by the UART transmitter and receiver. It generalises the fixed-divisor bit-clock counter in three ways: a fractional divisor, an oversampling tick for the receiver, and a runtime-loadable divisor. From one fabric clock it produces three single-cycle strobes: oversample tick, mid-bit sample tick and full-bit tick. Bit-period error stays below one clock cycle averaged over a frame.

## Interface
Parameters:
- CLK_HZ, 100_000_000: fabric clock frequency.
- BAUD, 115200: reset-time baud rate.
- OVS, 16: oversample ticks per bit. Even, ≥4.
- CNT_W, 16: integer divisor width.
- FRAC_W, 4: fractional divisor width.

Derived localparams:
- DIV_FX = (CLK_HZ·2^FRAC_W)/(BAUD·OVS), truncated.
- DEF_INT = DIV_FX>>FRAC_W.
- DEF_FRAC = DIV_FX mod 2^FRAC_W.
- Defaults give 868, so DEF_INT=54 and DEF_FRAC=4.

Ports:
- clk  in  1  fabric clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- en  in  1  count enable. Low holds and clears all counters.
- restart  in  1  synchronous phase realign. Clears all counters this edge.
- div_int  in  CNT_W  new integer divisor.
- div_frac  in  FRAC_W  new fractional divisor.
- div_load  in  1  one-cycle strobe that captures div_int/div_frac.
- ovs_tick  out  1  oversample strobe.
- mid_tick  out  1  mid-bit sample strobe.
- bit_tick  out  1  bit-boundary strobe.
- div_pending  out  1  captured divisor not yet active.

## Operation
- State:
  - cnt [CNT_W]: cycle counter.
  - acc [FRAC_W]: fractional accumulator.
  - c: carry bit.
  - idx: 0..OVS-1.
  - act_int/act_frac: active divisor.
  - sh_int/sh_frac: shadow divisor.
- Period rule: current oversample period length P = act_int + c.
- Clear conditions, in priority order:
  - restart=1: cnt, acc, c, idx ← 0 and all ticks ← 0.
  - Otherwise en=0: same clearing.
  - Otherwise counting.
- Counting:
  - If cnt == P-1: cnt←0, ovs_tick←1, and {c,acc} ← acc + act_frac (FRAC_W+1-bit sum).
  - Otherwise cnt←cnt+1.
- On each ovs_tick event, idx wraps at OVS-1.
  - mid_tick←1 when idx == OVS/2-1.
  - bit_tick←1 when idx == OVS-1.
- Average oversample period is act_int + act_frac/2^FRAC_W cycles.
- Divisor load:
  - div_load copies inputs to the shadow registers and sets div_pending.
  - The shadow is transferred to act_* at the next ovs_tick event, or on the next edge if en=0 or restart=1. That transfer clears div_pending.
  - A second div_load while pending overwrites the shadow. Last write wins.
  - div_load in the same cycle as a transfer: the new value goes to the shadow and pending stays set.
- Clamp: an incoming div_int < 2 is stored as 2.
- Reset values:
  - All counters 0; all ticks 0; div_pending 0.
  - act_* and sh_* = DEF_INT/DEF_FRAC.

## Timing
- All outputs are registered. Each tick is high for exactly one clk cycle.
- First ovs_tick is visible after edge N = act_int, counting the first edge with en sampled high as edge 1. Initial c=0.
- Coincidence: bit_tick coincides with an ovs_tick; mid_tick coincides with an ovs_tick. The two never coincide with each other.
- Defaults:
  - Periods cycle 54,54,54,55, repeating.
  - Bit period averages 868 cycles; 16 oversample periods sum to 868 exactly.
- en falling: ticks are 0 from the next edge.
- Re-enabling restarts phase from zero with acc=0.
- Reset mid-operation: all state returns to reset values immediately. An activated divisor is lost; defaults are restored.
- cnt never exceeds act_int. After a transfer that shrinks the divisor, cnt is 0 by construction because transfers occur only at cnt=0.

## Structure
- Shared package uart_pkg:
  - CLK_HZ default.
  - Function baud_div_fx(clk_hz, baud, ovs, frac_w) returning the fixed-point divisor.
  - The FRAC_W default.
- Sub-module uart_frac_div:
  - Contains cnt/acc/c and the active divisor.
  - Emits the raw oversample strobe.
- Top level contains idx, the tick decode and the shadow/load logic.

## Test plan
- Defaults, en=1 for 2000 cycles:
  - First ovs_tick after edge 54.
  - Period sequence 54,54,54,55.
  - bit_tick spacing exactly 868.
  - mid_tick 434 cycles after each bit boundary start.
- Drop en for 10 cycles mid-bit, then raise it: no ticks while low; first ovs_tick 54 edges after re-enable.
- div_load with int=6, frac=8 mid-period:
  - div_pending high until the next ovs_tick.
  - Subsequent periods 6,7 alternating.
  - bit_tick spacing 104.
- div_load with div_int=0: active divisor becomes 2. ovs_tick every 2 or 3 cycles per the fraction.
- Assert restart and div_load together with en=1: counters clear, new divisor active next edge, first tick after act_int edges.
- Assert rst_n low asynchronously mid-period after a loaded divisor: outputs 0 immediately; defaults restored on release.
